// File: rtl/clock_hms_counter.sv
// Time-of-day core: prescaled 1 s tick driving cascaded sec/min/hour fields,
// with a field-select set mode, a day-carry pulse and a 12/24-hour display.
module clock_hms_counter #(
  parameter int TICK_DIV = 50000000,
  parameter int SEC_MOD  = 60,
  parameter int MIN_MOD  = 60,
  parameter int HOUR_MOD = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic       set_en,
  input  logic [1:0] set_sel,
  input  logic       set_inc,
  input  logic       mode12,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic [4:0] disp_hour,
  output logic       pm,
  output logic       tick,
  output logic       carry_day
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [5:0] SEC_LAST  = 6'(SEC_MOD - 1);
  localparam logic [5:0] MIN_LAST  = 6'(MIN_MOD - 1);
  localparam logic [4:0] HOUR_LAST = 5'(HOUR_MOD - 1);
  localparam bit IS_24H = (HOUR_MOD == 24);

  typedef enum logic [1:0] {
    SEL_SEC  = 2'd0,
    SEL_MIN  = 2'd1,
    SEL_HOUR = 2'd2,
    SEL_NONE = 2'd3
  } sel_t;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'd0,
    MODE_SET  = 2'd1,
    MODE_HOLD = 2'd2
  } mode_t;

  logic [PW-1:0] presc;
  logic          inc_q;
  mode_t         mode;
  logic          presc_last;
  logic          run_tick;
  logic          set_fire;
  logic          sec_wrap;
  logic          min_wrap;
  logic          hour_wrap;
  logic [5:0]    sec_next;
  logic [5:0]    min_next;
  logic [4:0]    hour_next;

  // hold outranks set mode, which outranks normal counting
  always_comb begin
    mode = MODE_RUN;
    if (hold)
      mode = MODE_HOLD;
    else if (set_en)
      mode = MODE_SET;
  end

  assign presc_last = (presc == PRESC_LAST);
  assign run_tick   = (mode == MODE_RUN) && presc_last;
  assign set_fire   = (mode == MODE_SET) && set_inc && !inc_q;

  assign sec_wrap  = (sec == SEC_LAST);
  assign min_wrap  = (min == MIN_LAST);
  assign hour_wrap = (hour == HOUR_LAST);

  assign sec_next  = sec_wrap  ? 6'd0 : sec + 6'd1;
  assign min_next  = min_wrap  ? 6'd0 : min + 6'd1;
  assign hour_next = hour_wrap ? 5'd0 : hour + 5'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      presc <= '0;
    else if (mode == MODE_SET)
      presc <= '0;
    else if (mode == MODE_RUN)
      presc <= presc_last ? '0 : presc + PW'(1);
  end

  // sampled every cycle, even in hold, so a level held across hold release is not an edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      inc_q <= 1'b0;
    else
      inc_q <= set_inc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec  <= 6'd0;
      min  <= 6'd0;
      hour <= 5'd0;
    end else if (run_tick) begin
      sec <= sec_next;
      if (sec_wrap) begin
        min <= min_next;
        if (min_wrap)
          hour <= hour_next;
      end
    end else if (set_fire) begin
      case (sel_t'(set_sel))
        SEL_SEC:  sec  <= sec_next;
        SEL_MIN:  min  <= min_next;
        SEL_HOUR: hour <= hour_next;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick      <= 1'b0;
      carry_day <= 1'b0;
    end else begin
      tick      <= run_tick;
      carry_day <= run_tick && sec_wrap && min_wrap && hour_wrap;
    end
  end

  // 12-hour form only makes sense for a 24-hour day
  always_comb begin
    disp_hour = hour;
    pm        = 1'b0;
    if (IS_24H && mode12) begin
      if (hour == 5'd0) begin
        disp_hour = 5'd12;
      end else if (hour >= 5'd12) begin
        pm = 1'b1;
        if (hour > 5'd12)
          disp_hour = hour - 5'd12;
      end
    end
  end

endmodule

// File: tb/tb_clock_hms_counter.sv
// Self-checking bench for clock_hms_counter: directed and random steps checked
// against a seconds-of-day reference model.
module tb_clock_hms_counter;

  localparam int TICK_DIV = 4;
  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HOUR_MOD = 24;
  localparam int DAY      = SEC_MOD * MIN_MOD * HOUR_MOD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       hold = 1'b0;
  logic       set_en = 1'b0;
  logic [1:0] set_sel = 2'd3;
  logic       set_inc = 1'b0;
  logic       mode12 = 1'b0;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [4:0] disp_hour;
  logic       pm;
  logic       tick;
  logic       carry_day;

  int checks = 0;
  int failures = 0;

  int m_tod = 0;
  int m_phase = 0;
  bit m_prev = 1'b0;
  bit e_tick = 1'b0;
  bit e_carry = 1'b0;

  int tab_h[6] = '{0, 1, 11, 12, 13, 23};
  int tab_d[6] = '{12, 1, 11, 12, 1, 11};
  int tab_p[6] = '{0, 0, 0, 1, 1, 1};

  clock_hms_counter #(
    .TICK_DIV(TICK_DIV),
    .SEC_MOD(SEC_MOD),
    .MIN_MOD(MIN_MOD),
    .HOUR_MOD(HOUR_MOD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hold(hold),
    .set_en(set_en),
    .set_sel(set_sel),
    .set_inc(set_inc),
    .mode12(mode12),
    .sec(sec),
    .min(min),
    .hour(hour),
    .disp_hour(disp_hour),
    .pm(pm),
    .tick(tick),
    .carry_day(carry_day)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    int s, m, h;
    s = m_tod % SEC_MOD;
    m = (m_tod / SEC_MOD) % MIN_MOD;
    h = m_tod / (SEC_MOD * MIN_MOD);
    checkVal("sec", 32'(sec), s);
    checkVal("min", 32'(min), m);
    checkVal("hour", 32'(hour), h);
    checkVal("disp_hour", 32'(disp_hour), mode12 ? ((h + 11) % 12) + 1 : h);
    checkVal("pm", 32'(pm), (mode12 && h >= 12) ? 1 : 0);
    checkVal("tick", 32'(tick), 32'(e_tick));
    checkVal("carry_day", 32'(carry_day), 32'(e_carry));
  endtask

  task automatic modelSetInc(input logic [1:0] sel);
    int s, m, h;
    s = m_tod % SEC_MOD;
    m = (m_tod / SEC_MOD) % MIN_MOD;
    h = m_tod / (SEC_MOD * MIN_MOD);
    case (sel)
      2'd0: s = (s + 1) % SEC_MOD;
      2'd1: m = (m + 1) % MIN_MOD;
      2'd2: h = (h + 1) % HOUR_MOD;
      default: ;
    endcase
    m_tod = (h * MIN_MOD + m) * SEC_MOD + s;
  endtask

  // drive at the falling edge, advance the model at the rising edge, check 1 time unit later
  task automatic applyStimulus(input logic h, input logic se, input logic [1:0] sel,
                               input logic inc, input logic m12);
    hold = h;
    set_en = se;
    set_sel = sel;
    set_inc = inc;
    mode12 = m12;
    @(posedge clk);
    e_tick = 1'b0;
    e_carry = 1'b0;
    if (h) begin
    end else if (se) begin
      m_phase = 0;
      if (inc && !m_prev)
        modelSetInc(sel);
    end else begin
      m_phase++;
      if (m_phase == TICK_DIV) begin
        m_phase = 0;
        e_tick = 1'b1;
        e_carry = (m_tod == DAY - 1);
        m_tod = (m_tod + 1) % DAY;
      end
    end
    m_prev = inc;
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  // reset asserted between clock edges; outputs must clear without waiting for a clock
  task automatic doReset();
    #2 rst = 1'b0;
    m_tod = 0;
    m_phase = 0;
    m_prev = 1'b0;
    e_tick = 1'b0;
    e_carry = 1'b0;
    #1;
    checkOutput();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic pulseInc(input logic [1:0] sel, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, sel, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, sel, 1'b0, 1'b0);
    end
  endtask

  initial begin
    @(negedge clk);
    $display("[TB] reset and free run");
    doReset();
    for (int i = 0; i < 60 * TICK_DIV + 8; i++)
      applyStimulus(1'b0, 1'b0, 2'd3, 1'b0, 1'($urandom_range(0, 1)));

    $display("[TB] hold at 00:00:05");
    doReset();
    for (int i = 0; i < 5 * TICK_DIV + 2; i++)
      applyStimulus(1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'(i % 2), 1'b0);
    for (int i = 0; i < 3 * TICK_DIV; i++)
      applyStimulus(1'b0, 1'b0, 2'd3, 1'b0, 1'b0);

    $display("[TB] preload 23:59:59 and roll the day");
    doReset();
    pulseInc(2'd2, 23);
    pulseInc(2'd1, 59);
    pulseInc(2'd0, 59);
    for (int i = 0; i < 3 * TICK_DIV; i++)
      applyStimulus(1'b0, 1'b0, 2'd3, 1'b0, 1'b0);

    $display("[TB] minute wrap in set mode and held set_inc");
    doReset();
    pulseInc(2'd2, 7);
    pulseInc(2'd1, 59);
    pulseInc(2'd1, 1);
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
    pulseInc(2'd3, 3);

    $display("[TB] 12/24-hour display sweep");
    doReset();
    for (int h = 0; h < HOUR_MOD; h++) begin
      applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
      for (int k = 0; k < 6; k++) begin
        if (tab_h[k] == h) begin
          checkVal("tab_disp_hour", 32'(disp_hour), tab_d[k]);
          checkVal("tab_pm", 32'(pm), tab_p[k]);
        end
      end
      applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 2'd2, 1'b1, 1'b1);
    end

    $display("[TB] random stimulus");
    for (int i = 0; i < 600; i++)
      applyStimulus(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 4) == 0),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));

    $display("[TB] async reset in set mode at 12:34:56");
    doReset();
    pulseInc(2'd2, 12);
    pulseInc(2'd1, 34);
    pulseInc(2'd0, 56);
    doReset();
    for (int i = 0; i < 2 * TICK_DIV + 1; i++)
      applyStimulus(1'b0, 1'b0, 2'd3, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_hms_counter.md
Name: clock_hms_counter

Overview:
- Parametrised time-of-day core for the clock design. Generalises the standalone single-field hour counter into cascaded seconds/minutes/hours counters.
- Adds an internal tick prescaler, a field-select set mode with edge-detected increment, a day-carry pulse, and a 12/24-hour display output.
- Sits between the board clock/switch inputs and the 7-segment decode logic.

Parameters:
- TICK_DIV, 50000000, clk cycles per 1 s tick; legal range ≥2.
- SEC_MOD, 60, seconds modulus; legal range 2..64.
- MIN_MOD, 60, minutes modulus; legal range 2..64.
- HOUR_MOD, 24, hours modulus; legal range 2..32.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Asynchronous, active-low.
- hold  in  1  freeze everything: prescaler and all fields keep their value.
- set_en  in  1  set mode. Normal counting stops; fields are edited via set_inc.
- set_sel  in  2  field select in set mode: 0=sec, 1=min, 2=hour, 3=none.
- set_inc  in  1  level input. Each 0→1 edge increments the selected field.
- mode12  in  1  1 = 12-hour display, 0 = 24-hour display.
- sec  out  6  seconds, 0..SEC_MOD-1.
- min  out  6  minutes, 0..MIN_MOD-1.
- hour  out  5  hours, 0..HOUR_MOD-1.
- disp_hour  out  5  display hour (24h or 12h form).
- pm  out  1  PM flag in 12h mode.
- tick  out  1  one-cycle pulse on each counted second.
- carry_day  out  1  one-cycle pulse when hours wrap to 0 through normal counting.

Behaviour:
- Reset (rst=0, async): prescaler=0, sec=min=hour=0, set_inc edge register=0, tick=0, carry_day=0.
- Priority each cycle: hold > set_en > run.
- Edge register: always samples set_inc every cycle, including during hold. A held-high set_inc therefore produces no edge when hold is released.
- Run (hold=0, set_en=0):
  - Prescaler counts 0..TICK_DIV-1 and wraps to 0.
  - On the cycle prescaler==TICK_DIV-1: tick=1 for that clock (registered; visible the following cycle), and sec increments.
  - sec==SEC_MOD-1 → sec=0 and min increments.
  - min==MIN_MOD-1 on the same tick → min=0 and hour increments.
  - hour==HOUR_MOD-1 on the same tick → hour=0 and carry_day=1 for one cycle.
  - All field updates from one tick land in the same clock edge.
- Hold (hold=1): prescaler and all fields unchanged. tick=0, carry_day=0. set_inc edges are discarded.
- Set (hold=0, set_en=1):
  - Prescaler forced to 0. tick=0, carry_day=0.
  - On a rising edge of set_inc (registered previous value 0, current value 1), the selected field increments modulo its own MOD.
  - No carry into the next field; carry_day is never asserted in set mode.
  - set_sel=3: edges have no effect. Increment latency is 1 clk after the edge is sampled.
- Leaving set mode: counting resumes with prescaler=0, so the first tick comes exactly TICK_DIV cycles after set_en falls.
- Display is combinational from hour and mode12.
  - mode12=0, or HOUR_MOD≠24: disp_hour=hour, pm=0.
  - mode12=1 and HOUR_MOD=24: hour 0→12, pm=0; hour 1..11→same, pm=0; hour 12→12, pm=1; hour 13..23→hour-12, pm=1.
- Width rules: field output widths are fixed at 6/6/5 bits. Upper bits read 0 for smaller moduli. The prescaler width is $clog2(TICK_DIV).
- Reset mid-operation (e.g. during set mode or with a tick pending): all state clears immediately. No tick or carry_day pulse is emitted.

Test Plan:
- TICK_DIV=4, run from reset → tick pulses every 4 clks; sec reads 1 after the first tick; after 60 ticks sec=0, min=1.
- Preload 23:59:59 via set mode (23 hour edges, 59 min edges, 59 sec edges), then run → on the next tick 00:00:00, carry_day=1 for exactly one cycle, tick=1 on the same cycle.
- Set mode, set_sel=1 with min=59, one set_inc edge → min=0, hour unchanged, carry_day=0. set_inc held high for 10 clks gives a single increment.
- hold=1 asserted mid-count at 00:00:05 for 20 clks while toggling set_inc → fields stay 00:00:05 with no tick; counting resumes on release from the frozen prescaler value.
- mode12=1 sweep of hours 0, 1, 11, 12, 13, 23 → (disp_hour, pm) = (12,0), (1,0), (11,0), (12,1), (1,1), (11,1). With mode12=0, disp_hour=hour and pm=0.
- rst pulsed low asynchronously between clock edges in set mode at 12:34:56 → outputs are 0 immediately. After release, the first tick arrives after TICK_DIV clks.
